// File: rtl/roberts_stream_conv_ctrl.sv
// roberts_stream_conv_ctrl
//   Streaming 2x2 gradient-kernel sequencer. Four signed 8-bit coefficients
//   are loaded while idle. One raster-order frame of unsigned 8-bit pixels is
//   then streamed in. For every input pixel, exactly one output magnitude
//   |k00*A + k01*B + k10*C + k11*D| is emitted, clamped to 255. Border pixels
//   produce 0.
//
// Ports
//   clk, rst               clock (rising edge); asynchronous active-high reset
//   k_wr_en/idx/data       kernel coefficient write (accepted in IDLE only)
//   start                  frame start pulse (accepted in IDLE only)
//   busy, done             frame in progress / one-cycle end-of-frame pulse
//   s_valid/s_ready/s_data input pixel stream
//   m_valid/m_ready/m_data output magnitude stream
//   m_last                 marks the final output pixel of the frame
module roberts_stream_conv_ctrl #(
  parameter int ROWS = 512,
  parameter int COLS = 512,
  parameter int CW   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       k_wr_en,
  input  logic [1:0] k_wr_idx,
  input  logic [7:0] k_wr_data,
  input  logic       start,
  output logic       busy,
  output logic       done,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last
);

  localparam int LBW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0][7:0] k_q, k_d;
  logic [CW-1:0]   row_q, row_d, col_q, col_d;
  logic [7:0]      a_q, a_d, c_q, c_d;
  logic            mv_q, mv_d, ml_q, ml_d;
  logic [7:0]      md_q, md_d;

  // Line buffer holds the previous row. It is not reset because every entry is
  // written during row 0 before any interior pixel reads it.
  logic [7:0] lb_mem [COLS];
  logic [7:0] b_pix;

  logic in_hs, out_hs, last_px, border;
  logic signed [16:0] p00, p01, p10, p11;
  logic signed [18:0] sum;
  logic        [18:0] mag;
  logic        [7:0]  clamped;

  // Pixel times coefficient: zero-extend the pixel, sign-extend the coefficient.
  function automatic logic signed [16:0] pmul(input logic [7:0] p, input logic [7:0] k);
    logic signed [16:0] pe, ke;
    pe = 17'($signed({1'b0, p}));
    ke = 17'($signed(k));
    return pe * ke;
  endfunction

  assign s_ready = (state_q == RUN) && (!mv_q || m_ready);
  assign in_hs   = s_valid && s_ready;
  assign out_hs  = mv_q && m_ready;
  assign last_px = (row_q == LAST_ROW) && (col_q == LAST_COL);
  assign border  = (row_q == '0) || (col_q == '0) || (row_q == LAST_ROW) || (col_q == LAST_COL);

  assign b_pix = lb_mem[col_q[LBW-1:0]];

  assign p00 = pmul(a_q,    k_q[0]);
  assign p01 = pmul(b_pix,  k_q[1]);
  assign p10 = pmul(c_q,    k_q[2]);
  assign p11 = pmul(s_data, k_q[3]);
  assign sum = 19'(p00) + 19'(p01) + 19'(p10) + 19'(p11);
  assign mag = sum[18] ? 19'(-sum) : 19'(sum);
  assign clamped = (mag > 19'd255) ? 8'hFF : mag[7:0];

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign m_valid = mv_q;
  assign m_data  = md_q;
  assign m_last  = ml_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    row_d   = row_q;
    col_d   = col_q;
    a_d     = a_q;
    c_d     = c_q;
    mv_d    = mv_q;
    md_d    = md_q;
    ml_d    = ml_q;

    case (state_q)
      IDLE: begin
        if (k_wr_en) k_d[k_wr_idx] = k_wr_data;
        if (start) begin
          state_d = RUN;
          row_d   = '0;
          col_d   = '0;
        end
      end
      RUN:     if (in_hs && last_px) state_d = DRAIN;
      DRAIN:   if (out_hs && ml_q)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The output register reloads on an input handshake, even if it is being
    // drained in the same cycle. This keeps throughput at one pixel per cycle.
    if (in_hs) begin
      mv_d = 1'b1;
      md_d = border ? 8'd0 : clamped;
      ml_d = last_px;
      a_d  = b_pix;   // B of this column becomes A of the next
      c_d  = s_data;  // D of this column becomes C of the next
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end else if (out_hs) begin
      mv_d = 1'b0;
      ml_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      a_q     <= '0;
      c_q     <= '0;
      mv_q    <= 1'b0;
      md_q    <= '0;
      ml_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      row_q   <= row_d;
      col_q   <= col_d;
      a_q     <= a_d;
      c_q     <= c_d;
      mv_q    <= mv_d;
      md_q    <= md_d;
      ml_q    <= ml_d;
    end
  end

  // The old B is read combinationally above, then replaced by D.
  always_ff @(posedge clk) begin
    if (in_hs) lb_mem[col_q[LBW-1:0]] <= s_data;
  end

endmodule

// File: tb/tb_roberts_stream_conv_ctrl.sv
module tb_roberts_stream_conv_ctrl;
  localparam int R = 4;
  localparam int C = 4;

  logic       clk = 1'b0, rst = 1'b1;
  logic       k_wr_en = 1'b0, start = 1'b0, s_valid = 1'b0, m_ready = 1'b1;
  logic [1:0] k_wr_idx = '0;
  logic [7:0] k_wr_data = '0, s_data = '0;
  logic       busy, done, s_ready, m_valid, m_last;
  logic [7:0] m_data;

  roberts_stream_conv_ctrl #(.ROWS(R), .COLS(C), .CW(3)) dut (
    .clk(clk), .rst(rst),
    .k_wr_en(k_wr_en), .k_wr_idx(k_wr_idx), .k_wr_data(k_wr_data),
    .start(start), .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int exp_q[$];
  int kern[4];
  int pix[R][C];
  int out_cnt = 0;
  bit rand_rdy = 0, stall_arm = 0, rand_gap = 0;
  int stall_left = 0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: the direct window sum over the frame array, abs, clamp, zero border.
  function automatic int ref_px(input int i, input int j);
    int s;
    if (i == 0 || j == 0 || i == R-1 || j == C-1) return 0;
    s = kern[0]*pix[i-1][j-1] + kern[1]*pix[i-1][j] + kern[2]*pix[i][j-1] + kern[3]*pix[i][j];
    if (s < 0) s = -s;
    return (s > 255) ? 255 : s;
  endfunction

  task automatic push_frame();
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        exp_q.push_back(ref_px(i, j) | ((i == R-1 && j == C-1) ? 256 : 0));
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic load_kernel(input int a, input int b, input int c, input int d);
    int kv[4];
    kv = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      k_wr_en = 1'b1; k_wr_idx = 2'(i); k_wr_data = 8'(kv[i]); kern[i] = kv[i];
      cyc();
    end
    k_wr_en = 1'b0;
  endtask

  task automatic start_frame();
    out_cnt = 0;
    push_frame();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic send_px(input int d);
    int t;
    bit ok;
    t = 0; ok = 0;
    if (rand_gap && $urandom_range(0, 3) == 0) cyc();
    s_valid = 1'b1; s_data = 8'(d);
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = s_ready;
      cyc();
      t++;
    end
    if (!ok) chk("s_ready_timeout", 0, 1);
    s_valid = 1'b0;
  endtask

  task automatic send_range(input int from, input int to);
    for (int n = from; n < to; n++) send_px(pix[n / C][n % C]);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 300) begin @(negedge clk); n++; end
    chk("done_seen", int'(done), 1);
    chk("busy_in_done", int'(busy), 1);
    chk("outputs_left", exp_q.size(), 0);
    chk("output_count", out_cnt, R*C);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("busy_after_done", int'(busy), 0);
    cyc();
  endtask

  task automatic set_pix_ramp();
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) pix[i][j] = 10*i + j;
  endtask

  task automatic set_pix_const(input int v);
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) pix[i][j] = v;
  endtask

  task automatic set_pix_rand();
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) pix[i][j] = int'($urandom_range(0, 255));
  endtask

  // Output sink ready: always-on, random, or a one-shot 5-cycle stall at output 6.
  initial forever begin
    @(posedge clk); #1;
    if (stall_left > 0) begin
      m_ready = 1'b0; stall_left--;
    end else if (stall_arm && m_valid && out_cnt == 5) begin
      m_ready = 1'b0; stall_left = 4; stall_arm = 0;
    end else begin
      m_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks
  // that the output holds stable while it is stalled.
  initial begin
    bit prev_stall;
    int prev_data, prev_last, e;
    prev_stall = 0; prev_data = 0; prev_last = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (m_valid && !m_ready) chk("s_ready_in_stall", int'(s_ready), 0);
        if (prev_stall && m_valid) begin
          chk("stall_data_hold", int'(m_data), prev_data);
          chk("stall_last_hold", int'(m_last), prev_last);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("m_data", int'(m_data), e & 255);
            chk("m_last", int'(m_last), e >> 8);
          end
          out_cnt++;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = int'(m_data);
        prev_last  = int'(m_last);
      end
    end
  end

  initial begin
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_m_last", int'(m_last), 0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Directed ramp frame with the exact done timing.
    load_kernel(1, 0, 0, -1);
    set_pix_ramp();
    start_frame();
    send_range(0, R*C);
    @(negedge clk);
    chk("done_early", int'(done), 0);
    @(negedge clk);
    chk("done_at_2", int'(done), 1);
    chk("outputs_left", exp_q.size(), 0);
    @(negedge clk);
    chk("done_clear", int'(done), 0);
    chk("busy_clear", int'(busy), 0);
    cyc();

    // Clamp and sign frames.
    load_kernel(127, 127, 127, 127);
    set_pix_const(255);
    start_frame(); send_range(0, R*C); wait_done();
    load_kernel(-128, -128, -128, -128);
    start_frame(); send_range(0, R*C); wait_done();
    load_kernel(0, 0, 0, -1);
    set_pix_const(100);
    start_frame(); send_range(0, R*C); wait_done();

    // Backpressure: 5-cycle stall at output 6.
    load_kernel(1, 0, 0, -1);
    set_pix_ramp();
    stall_arm = 1;
    start_frame(); send_range(0, R*C); wait_done();
    chk("stall_happened", int'(stall_arm), 0);

    // Guards: kernel write and start during RUN are ignored.
    start_frame();
    send_range(0, 3);
    k_wr_en = 1'b1; k_wr_idx = 2'd3; k_wr_data = 8'd5; start = 1'b1;
    cyc();
    k_wr_en = 1'b0; start = 1'b0;
    send_range(3, R*C);
    wait_done();
    // The same write in IDLE applies to the next frame.
    k_wr_en = 1'b1; k_wr_idx = 2'd3; k_wr_data = 8'd5; kern[3] = 5;
    cyc();
    k_wr_en = 1'b0;
    start_frame(); send_range(0, R*C); wait_done();

    // Random kernels and pixels, with random gaps and backpressure.
    rand_gap = 1; rand_rdy = 1;
    for (int f = 0; f < 4; f++) begin
      load_kernel(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
      set_pix_rand();
      start_frame(); send_range(0, R*C); wait_done();
    end
    rand_gap = 0; rand_rdy = 0;

    // Mid-frame reset after 6 input pixels.
    load_kernel(1, 0, 0, -1);
    set_pix_ramp();
    start_frame();
    send_range(0, 6);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_m_valid", int'(m_valid), 0);
    chk("mid_rst_s_ready", int'(s_ready), 0);
    chk("mid_rst_m_data", int'(m_data), 0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) kern[i] = 0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    // The kernel was cleared, so every output is 0.
    set_pix_rand();
    start_frame(); send_range(0, R*C); wait_done();
    load_kernel(1, 0, 0, -1);
    set_pix_ramp();
    start_frame(); send_range(0, R*C); wait_done();

    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
